// File: rtl/toast_wb_unit_if.sv
// Toast RV32i writeback: MEM-side, data-memory and register-file signals.
// The master drives MEM/dmem inputs; the slave is the writeback unit.
interface toast_wb_unit_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 64
);
  logic            MEM_valid_i;
  logic [4:0]      MEM_rd_addr_i;
  logic [XLEN-1:0] MEM_alu_result_i;
  logic            MEM_memtoreg_i;
  logic            MEM_rd_wr_en_i;
  logic [2:0]      MEM_funct3_i;
  logic            WB_flush_i;
  logic            dmem_rvalid_i;
  logic [XLEN-1:0] dmem_rdata_i;
  logic            WB_stall_o;
  logic [4:0]      WB_rd_addr_o;
  logic [XLEN-1:0] WB_rd_wr_data_o;
  logic            WB_rd_wr_en_o;
  logic            WB_retire_o;
  logic            WB_load_err_o;
  logic [CNT_W-1:0] WB_instret_o;

  modport slave (
    input  MEM_valid_i, MEM_rd_addr_i, MEM_alu_result_i,
    input  MEM_memtoreg_i, MEM_rd_wr_en_i, MEM_funct3_i,
    input  WB_flush_i, dmem_rvalid_i, dmem_rdata_i,
    output WB_stall_o, WB_rd_addr_o, WB_rd_wr_data_o,
    output WB_rd_wr_en_o, WB_retire_o, WB_load_err_o,
    output WB_instret_o
  );

  modport master (
    output MEM_valid_i, MEM_rd_addr_i, MEM_alu_result_i,
    output MEM_memtoreg_i, MEM_rd_wr_en_i, MEM_funct3_i,
    output WB_flush_i, dmem_rvalid_i, dmem_rdata_i,
    input  WB_stall_o, WB_rd_addr_o, WB_rd_wr_data_o,
    input  WB_rd_wr_en_o, WB_retire_o, WB_load_err_o,
    input  WB_instret_o
  );
endinterface

// File: rtl/toast_wb_unit.sv
// Toast RV32i registered writeback stage: MEM/WB register, load
// formatting, dmem response wait with timeout, retired-instruction count.
module toast_wb_unit #(
  parameter int XLEN         = 32,
  parameter int CNT_W        = 64,
  parameter int LOAD_TIMEOUT = 16
) (
  input logic             clk_i,
  input logic             resetn_i,
  toast_wb_unit_if.slave  wb
);
  localparam int TW = $clog2(LOAD_TIMEOUT + 1);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t           r_state;
  logic [4:0]       r_ld_rd;
  logic             r_ld_wen;
  logic [2:0]       r_ld_f3;
  logic [1:0]       r_ld_off;
  logic [TW-1:0]    r_tcnt;
  logic [4:0]       r_rd_addr;
  logic [XLEN-1:0]  r_wr_data;
  logic             r_wr_en;
  logic             r_retire;
  logic             r_load_err;
  logic [CNT_W-1:0] r_instret;

  logic             w_accept;
  logic             w_tmo;
  logic [7:0]       w_byte;
  logic [15:0]      w_half;
  logic [XLEN-1:0]  w_ld_data;

  assign w_accept = wb.MEM_valid_i && !wb.WB_flush_i
                  && (r_state == S_IDLE);
  assign w_tmo    = (r_tcnt == TW'(LOAD_TIMEOUT - 1));

  always_comb begin
    w_byte = wb.dmem_rdata_i[8*r_ld_off +: 8];
    w_half = r_ld_off[1] ? wb.dmem_rdata_i[31:16]
                         : wb.dmem_rdata_i[15:0];
    case (r_ld_f3)
      3'b000:  w_ld_data = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_ld_data = {{16{w_half[15]}}, w_half};
      3'b100:  w_ld_data = {24'd0, w_byte};
      3'b101:  w_ld_data = {16'd0, w_half};
      default: w_ld_data = wb.dmem_rdata_i;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      r_state    <= S_IDLE;
      r_ld_rd    <= '0;
      r_ld_wen   <= 1'b0;
      r_ld_f3    <= '0;
      r_ld_off   <= '0;
      r_tcnt     <= '0;
      r_rd_addr  <= '0;
      r_wr_data  <= '0;
      r_wr_en    <= 1'b0;
      r_retire   <= 1'b0;
      r_load_err <= 1'b0;
      r_instret  <= '0;
    end else begin
      r_wr_en    <= 1'b0;
      r_retire   <= 1'b0;
      r_load_err <= 1'b0;
      r_instret  <= r_instret + CNT_W'(r_retire);
      case (r_state)
        S_IDLE: begin
          if (w_accept && !wb.MEM_memtoreg_i) begin
            r_rd_addr <= wb.MEM_rd_addr_i;
            r_wr_data <= wb.MEM_alu_result_i;
            r_wr_en   <= wb.MEM_rd_wr_en_i
                       && (wb.MEM_rd_addr_i != 5'd0);
            r_retire  <= 1'b1;
          end else if (w_accept) begin
            r_ld_rd  <= wb.MEM_rd_addr_i;
            r_ld_wen <= wb.MEM_rd_wr_en_i;
            r_ld_f3  <= wb.MEM_funct3_i;
            r_ld_off <= wb.MEM_alu_result_i[1:0];
            r_tcnt   <= '0;
            r_state  <= S_WAIT;
          end
        end
        S_WAIT: begin
          // rvalid takes priority over the timeout threshold
          if (wb.dmem_rvalid_i) begin
            r_rd_addr <= r_ld_rd;
            r_wr_data <= w_ld_data;
            r_wr_en   <= r_ld_wen && (r_ld_rd != 5'd0);
            r_retire  <= 1'b1;
            r_state   <= S_IDLE;
          end else if (w_tmo) begin
            r_load_err <= 1'b1;
            r_state    <= S_IDLE;
          end else begin
            r_tcnt <= r_tcnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign wb.WB_stall_o      = (r_state == S_WAIT);
  assign wb.WB_rd_addr_o    = r_rd_addr;
  assign wb.WB_rd_wr_data_o = r_wr_data;
  assign wb.WB_rd_wr_en_o   = r_wr_en;
  assign wb.WB_retire_o     = r_retire;
  assign wb.WB_load_err_o   = r_load_err;
  assign wb.WB_instret_o    = r_instret;
endmodule

// File: tb/tb_toast_wb_unit.sv
// Randomized scoreboard bench for toast_wb_unit: the driver queues the
// expected writeback of each accepted instruction, a monitor pops on pulses.
module tb_toast_wb_unit;
  localparam int LT = 16;

  typedef struct {
    bit          ret;
    bit          wen;
    bit          err;
    logic [4:0]  addr;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;
  logic [63:0] exp_cnt = '0;
  exp_t q[$];

  toast_wb_unit_if #(.XLEN(32), .CNT_W(64)) bus ();

  toast_wb_unit #(
    .XLEN(32), .CNT_W(64), .LOAD_TIMEOUT(LT)
  ) dut (
    .clk_i(clk),
    .resetn_i(resetn),
    .wb(bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Load result from the ISA rules, using plain shift/mask arithmetic
  function automatic logic [31:0] fmt(input logic [2:0] f3,
                                      input logic [1:0] off,
                                      input logic [31:0] w);
    logic [31:0] b, h;
    b = (w >> (8 * off)) & 32'hFF;
    h = (w >> (16 * off[1])) & 32'hFFFF;
    case (f3)
      3'b000:  return (b >= 32'd128) ? b - 32'd256 : b;
      3'b001:  return (h >= 32'd32768) ? h - 32'd65536 : h;
      3'b100:  return b;
      3'b101:  return h;
      default: return w;
    endcase
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      chk("instret", bus.WB_instret_o, exp_cnt);
      if (bus.WB_retire_o || bus.WB_load_err_o || bus.WB_rd_wr_en_o) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse: got ret=%0b wen=%0b err=%0b expected none at %0t",
                   bus.WB_retire_o, bus.WB_rd_wr_en_o, bus.WB_load_err_o, $time);
        end else begin
          e = q.pop_front();
          chk("retire", 64'(bus.WB_retire_o), 64'(e.ret));
          chk("wr_en", 64'(bus.WB_rd_wr_en_o), 64'(e.wen));
          chk("load_err", 64'(bus.WB_load_err_o), 64'(e.err));
          if (e.ret) begin
            chk("rd_addr", 64'(bus.WB_rd_addr_o), 64'(e.addr));
            chk("wr_data", 64'(bus.WB_rd_wr_data_o), 64'(e.data));
            exp_cnt = exp_cnt + 64'd1;
          end
        end
      end
    end
  end

  task automatic idle_inputs();
    bus.MEM_valid_i      = 1'b0;
    bus.MEM_rd_addr_i    = '0;
    bus.MEM_alu_result_i = '0;
    bus.MEM_memtoreg_i   = 1'b0;
    bus.MEM_rd_wr_en_i   = 1'b0;
    bus.MEM_funct3_i     = '0;
    bus.WB_flush_i       = 1'b0;
    bus.dmem_rvalid_i    = 1'b0;
    bus.dmem_rdata_i     = '0;
  endtask

  task automatic do_alu(input logic [4:0] rd, input logic [31:0] alu,
                        input bit wen, input bit fl);
    exp_t e;
    bus.MEM_valid_i      = 1'b1;
    bus.MEM_memtoreg_i   = 1'b0;
    bus.MEM_rd_addr_i    = rd;
    bus.MEM_alu_result_i = alu;
    bus.MEM_rd_wr_en_i   = wen;
    bus.MEM_funct3_i     = 3'($urandom);
    bus.WB_flush_i       = fl;
    bus.dmem_rvalid_i    = 1'($urandom);
    chk("stall_idle", 64'(bus.WB_stall_o), 64'd0);
    if (!fl) begin
      e = '{1'b1, wen && (rd != 5'd0), 1'b0, rd, alu};
      q.push_back(e);
    end
    tick();
    idle_inputs();
  endtask

  // s = cycle of WAIT (1-based) in which rvalid is driven
  task automatic do_load(input logic [4:0] rd, input logic [31:0] addr,
                         input logic [2:0] f3, input bit wen,
                         input int s, input logic [31:0] rdata);
    exp_t e;
    int n;
    bus.MEM_valid_i      = 1'b1;
    bus.MEM_memtoreg_i   = 1'b1;
    bus.MEM_rd_addr_i    = rd;
    bus.MEM_alu_result_i = addr;
    bus.MEM_rd_wr_en_i   = wen;
    bus.MEM_funct3_i     = f3;
    bus.WB_flush_i       = 1'b0;
    chk("stall_idle", 64'(bus.WB_stall_o), 64'd0);
    if (s <= LT) e = '{1'b1, wen && (rd != 5'd0), 1'b0, rd, fmt(f3, addr[1:0], rdata)};
    else         e = '{1'b0, 1'b0, 1'b1, 5'd0, 32'd0};
    q.push_back(e);
    tick();
    idle_inputs();
    n = 0;
    while (bus.WB_stall_o && n < 40) begin
      n++;
      bus.dmem_rvalid_i    = (n == s);
      bus.dmem_rdata_i     = (n == s) ? rdata : $urandom;
      bus.MEM_valid_i      = 1'($urandom);
      bus.WB_flush_i       = 1'($urandom);
      bus.MEM_memtoreg_i   = 1'($urandom);
      bus.MEM_rd_addr_i    = 5'($urandom);
      bus.MEM_rd_wr_en_i   = 1'b1;
      bus.MEM_alu_result_i = $urandom;
      tick();
    end
    idle_inputs();
    chk("stall_cycles", 64'(n), 64'((s < LT) ? s : LT));
  endtask

  initial begin
    idle_inputs();
    resetn = 1'b0;
    tick();
    tick();
    chk("rst_stall", 64'(bus.WB_stall_o), 64'd0);
    chk("rst_wen", 64'(bus.WB_rd_wr_en_o), 64'd0);
    chk("rst_retire", 64'(bus.WB_retire_o), 64'd0);
    chk("rst_err", 64'(bus.WB_load_err_o), 64'd0);
    chk("rst_addr", 64'(bus.WB_rd_addr_o), 64'd0);
    chk("rst_data", 64'(bus.WB_rd_wr_data_o), 64'd0);
    chk("rst_instret", bus.WB_instret_o, 64'd0);
    resetn = 1'b1;
    mon_en = 1'b1;

    do_alu(5'd5, 32'h0000_1234, 1'b1, 1'b0);
    tick();
    do_load(5'd7, 32'h0000_0103, 3'b000, 1'b1, 2, 32'h80FF_0000);
    do_load(5'd7, 32'h0000_0103, 3'b100, 1'b1, 2, 32'h80FF_0000);
    do_load(5'd8, 32'h0000_0012, 3'b001, 1'b1, 1, 32'h8001_7FFF);
    do_load(5'd8, 32'h0000_0012, 3'b101, 1'b1, 1, 32'h8001_7FFF);
    do_load(5'd8, 32'h0000_0012, 3'b010, 1'b1, 1, 32'h8001_7FFF);
    do_load(5'd9, 32'h0000_0000, 3'b010, 1'b1, LT + 4, 32'h0);
    do_load(5'd9, 32'h0000_0001, 3'b000, 1'b1, LT, 32'h0000_AB00);
    do_alu(5'd3, 32'hDEAD_BEEF, 1'b1, 1'b1);
    do_alu(5'd0, 32'hCAFE_0000, 1'b1, 1'b0);
    do_load(5'd0, 32'h0000_0002, 3'b110, 1'b1, 3, 32'h1234_5678);

    // reset while a load waits: nothing completes and instret clears
    bus.MEM_valid_i    = 1'b1;
    bus.MEM_memtoreg_i = 1'b1;
    bus.MEM_rd_addr_i  = 5'd4;
    bus.MEM_rd_wr_en_i = 1'b1;
    tick();
    idle_inputs();
    tick();
    tick();
    chk("wait_stall", 64'(bus.WB_stall_o), 64'd1);
    resetn = 1'b0;
    tick();
    exp_cnt = '0;
    chk("rstw_stall", 64'(bus.WB_stall_o), 64'd0);
    chk("rstw_pulses", 64'({bus.WB_rd_wr_en_o, bus.WB_retire_o,
                            bus.WB_load_err_o}), 64'd0);
    chk("rstw_instret", bus.WB_instret_o, 64'd0);
    resetn = 1'b1;
    bus.dmem_rvalid_i = 1'b1;
    bus.dmem_rdata_i  = 32'hFFFF_FFFF;
    tick();
    tick();
    idle_inputs();

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 2) == 0)
        do_load(5'($urandom), $urandom, 3'($urandom), 1'($urandom),
                ($urandom_range(0, 7) == 0) ? $urandom_range(LT - 1, LT + 3)
                                            : $urandom_range(1, 5),
                $urandom);
      else
        do_alu(5'($urandom), $urandom, 1'($urandom),
               $urandom_range(0, 4) == 0);
      if ($urandom_range(0, 3) == 0) tick();
    end

    tick();
    tick();
    chk("queue_empty", 64'(q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
